// File: rtl/systolic_sequencer_if.sv
// Host/buffer/array-facing bundle of the systolic sequencer: start request,
// status, per-lane buffer read ports and array edge valid/clear lines.
interface systolic_sequencer_if #(
    parameter int ROWS    = 4,
    parameter int COLUMNS = 4,
    parameter int KW      = 8
);
    logic                      Start;
    logic [KW-1:0]             K_Len;
    logic                      Busy;
    logic                      Done;
    logic [COLUMNS-1:0]        Act_Rd_En;
    logic [COLUMNS*KW-1:0]     Act_Rd_Addr;
    logic [ROWS-1:0]           Weight_Rd_En;
    logic [ROWS*KW-1:0]        Weight_Rd_Addr;
    logic [COLUMNS-1:0]        Act_Valids;
    logic [ROWS-1:0]           Weight_Valids;
    logic [ROWS-1:0]           Clear_Row;
    logic [COLUMNS-1:0]        Clear_Col;

    modport master (
        output Start, K_Len,
        input  Busy, Done, Act_Rd_En, Act_Rd_Addr, Weight_Rd_En, Weight_Rd_Addr,
        input  Act_Valids, Weight_Valids, Clear_Row, Clear_Col
    );

    modport slave (
        input  Start, K_Len,
        output Busy, Done, Act_Rd_En, Act_Rd_Addr, Weight_Rd_En, Weight_Rd_Addr,
        output Act_Valids, Weight_Valids, Clear_Row, Clear_Col
    );
endinterface

// File: rtl/systolic_sequencer.sv
// Control FSM for one matrix-multiply pass on a ROWS x COLUMNS systolic array.
// Optional early termination input Abort is enabled by SYSTOLIC_SEQ_ABORT_EN.
module systolic_sequencer #(
    parameter int ROWS         = 4,
    parameter int COLUMNS      = 4,
    parameter int KW           = 8,
    parameter int NODE_LATENCY = 2
) (
    input  logic Clock,
    input  logic Reset,
`ifdef SYSTOLIC_SEQ_ABORT_EN
    input  logic Abort,
`endif
    systolic_sequencer_if.slave bus
);
    localparam int MAXRC     = (ROWS > COLUMNS) ? ROWS : COLUMNS;
    localparam int TW        = KW + 1;
    localparam int DRAIN_CYC = ROWS + COLUMNS + NODE_LATENCY;
    localparam int DW        = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [TW-1:0]         t_q, t_d;
    logic [DW-1:0]         drn_q, drn_d;
    logic [TW-1:0]         last_t;
    logic                  abort;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [COLUMNS-1:0]    act_en_q, act_en_d;
    logic [COLUMNS*KW-1:0] act_addr_q, act_addr_d;
    logic [ROWS-1:0]       w_en_q, w_en_d;
    logic [ROWS*KW-1:0]    w_addr_q, w_addr_d;
    logic [COLUMNS-1:0]    act_vld_q, act_vld_d;
    logic [ROWS-1:0]       w_vld_q, w_vld_d;
    logic [ROWS-1:0]       clr_row_q, clr_row_d;
    logic [COLUMNS-1:0]    clr_col_q, clr_col_d;

`ifdef SYSTOLIC_SEQ_ABORT_EN
    assign abort = Abort && (state_q != IDLE);
`else
    assign abort = 1'b0;
`endif

    // Last step index: K-1 for lane 0 plus the skew of the farthest lane.
    assign last_t = TW'(k_q) + TW'(MAXRC) - TW'(2);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        t_d     = t_q;
        drn_d   = drn_q;
        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d = CLEAR;
                    k_d     = bus.K_Len;
                end
            end
            CLEAR: begin
                t_d     = '0;
                state_d = (k_q != '0) ? STREAM : DONE;
            end
            STREAM: begin
                if (t_q == last_t) begin
                    state_d = DRAIN;
                    drn_d   = '0;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            DRAIN: begin
                if (drn_q == DW'(DRAIN_CYC - 1)) state_d = DONE;
                else                             drn_d   = drn_q + DW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        act_en_d   = '0;
        act_addr_d = '0;
        w_en_d     = '0;
        w_addr_d   = '0;
        for (int c = 0; c < COLUMNS; c++) begin
            act_en_d[c] = (state_d == STREAM) && (int'(t_d) >= c) && (int'(t_d) < c + int'(k_d));
            if (act_en_d[c]) act_addr_d[c*KW +: KW] = KW'(t_d - TW'(c));
        end
        for (int r = 0; r < ROWS; r++) begin
            w_en_d[r] = (state_d == STREAM) && (int'(t_d) >= r) && (int'(t_d) < r + int'(k_d));
            if (w_en_d[r]) w_addr_d[r*KW +: KW] = KW'(t_d - TW'(r));
        end
        act_vld_d = (state_d == IDLE) ? '0 : act_en_q;
        w_vld_d   = (state_d == IDLE) ? '0 : w_en_q;
        clr_row_d = (state_d == CLEAR) ? '1 : '0;
        clr_col_d = (state_d == CLEAR) ? '1 : '0;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            t_q        <= '0;
            drn_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            act_en_q   <= '0;
            act_addr_q <= '0;
            w_en_q     <= '0;
            w_addr_q   <= '0;
            act_vld_q  <= '0;
            w_vld_q    <= '0;
            clr_row_q  <= '0;
            clr_col_q  <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            t_q        <= t_d;
            drn_q      <= drn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            act_en_q   <= act_en_d;
            act_addr_q <= act_addr_d;
            w_en_q     <= w_en_d;
            w_addr_q   <= w_addr_d;
            act_vld_q  <= act_vld_d;
            w_vld_q    <= w_vld_d;
            clr_row_q  <= clr_row_d;
            clr_col_q  <= clr_col_d;
        end
    end

    assign bus.Busy           = busy_q;
    assign bus.Done           = done_q;
    assign bus.Act_Rd_En      = act_en_q;
    assign bus.Act_Rd_Addr    = act_addr_q;
    assign bus.Weight_Rd_En   = w_en_q;
    assign bus.Weight_Rd_Addr = w_addr_q;
    assign bus.Act_Valids     = act_vld_q;
    assign bus.Weight_Valids  = w_vld_q;
    assign bus.Clear_Row      = clr_row_q;
    assign bus.Clear_Col      = clr_col_q;
endmodule

// File: tb/tb_systolic_sequencer.sv
// Self-checking bench for systolic_sequencer: cycle-indexed pass model plus a
// behavioural array model that tracks where each step's operands meet.
module tb_systolic_sequencer;
    localparam int R     = 4;
    localparam int C     = 4;
    localparam int KW    = 8;
    localparam int NL    = 2;
    localparam int M     = (R > C) ? R : C;
    localparam int CTLW  = 2 + 3*R + 3*C;
    localparam int OUTW  = 2 + 3*R + 3*C + (R + C)*KW;

    logic clk = 1'b0;
    logic rst;
`ifdef SYSTOLIC_SEQ_ABORT_EN
    logic abort;
`endif
    int checks = 0;
    int errors = 0;

    systolic_sequencer_if #(.ROWS(R), .COLUMNS(C), .KW(KW)) bus ();

    systolic_sequencer #(.ROWS(R), .COLUMNS(C), .KW(KW), .NODE_LATENCY(NL)) dut (
        .Clock(clk),
        .Reset(rst),
`ifdef SYSTOLIC_SEQ_ABORT_EN
        .Abort(abort),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OUTW-1:0] all_out();
        return {bus.Busy, bus.Done, bus.Clear_Row, bus.Clear_Col, bus.Act_Rd_En, bus.Weight_Rd_En,
                bus.Act_Valids, bus.Weight_Valids, bus.Act_Rd_Addr, bus.Weight_Rd_Addr};
    endfunction

    // Cycle index i counts from the cycle in which Start is presented (i = 0).
    function automatic int pass_len(int k);
        return (k > 0) ? 3 + (k + M - 1) + (R + C + NL) : 3;
    endfunction

    function automatic logic [15:0] exp_en(int lanes, int k, int i);
        logic [15:0] v;
        int t, s;
        v = '0;
        t = i - 2;
        s = (k > 0) ? k + M - 1 : 0;
        if (t >= 0 && t < s)
            for (int l = 0; l < lanes; l++) v[l] = (t >= l) && (t < l + k);
        return v;
    endfunction

    function automatic logic [63:0] exp_addr(int lanes, int k, int i);
        logic [63:0] v;
        logic [15:0] en;
        v  = '0;
        en = exp_en(lanes, k, i);
        for (int l = 0; l < lanes; l++)
            if (en[l]) v[l*KW +: KW] = KW'(i - 2 - l);
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (all_out() !== '0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got %h required 0", i, all_out());
            end
        end
    endtask

    task automatic test_pass(input int k, input bit disturb);
        int L;
        logic [15:0] ea, ew, eav, ewv;
        logic [63:0] aa, wa;
        logic [CTLW-1:0] got_c, exp_c;
        logic [(R+C)*KW-1:0] got_a, exp_a;
        L = pass_len(k);
        bus.K_Len = KW'(k);
        bus.Start = 1'b1;
        tick();
        for (int i = 1; i <= L; i++) begin
            ea  = exp_en(C, k, i);
            ew  = exp_en(R, k, i);
            eav = exp_en(C, k, i - 1);
            ewv = exp_en(R, k, i - 1);
            aa  = exp_addr(C, k, i);
            wa  = exp_addr(R, k, i);
            exp_c = {(i <= L - 1), (i == L - 1), (i == 1) ? {R{1'b1}} : {R{1'b0}},
                     (i == 1) ? {C{1'b1}} : {C{1'b0}}, ea[C-1:0], ew[R-1:0], eav[C-1:0], ewv[R-1:0]};
            got_c = {bus.Busy, bus.Done, bus.Clear_Row, bus.Clear_Col, bus.Act_Rd_En,
                     bus.Weight_Rd_En, bus.Act_Valids, bus.Weight_Valids};
            checks++;
            if (got_c !== exp_c) begin
                errors++;
                $display("FAIL pass_ctl k=%0d cyc=%0d got %h required %h", k, i, got_c, exp_c);
            end
            exp_a = {wa[R*KW-1:0], aa[C*KW-1:0]};
            got_a = {bus.Weight_Rd_Addr, bus.Act_Rd_Addr};
            checks++;
            if (got_a !== exp_a) begin
                errors++;
                $display("FAIL pass_addr k=%0d cyc=%0d got %h required %h", k, i, got_a, exp_a);
            end
            bus.Start = (disturb && i < L) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (disturb) bus.K_Len = KW'($urandom_range(0, 255));
            tick();
        end
    endtask

    // Array model: node (r,c) sees column c's edge activation r cycles late and
    // row r's edge weight c cycles late; buffers return data equal to address.
    task automatic test_meet();
        int L, k, na, nw, da, dw;
        int meets[R][C];
        bit av_h[64][C], ae_h[64][C], wv_h[64][R], we_h[64][R];
        int aa_h[64][C], wa_h[64][R];
        k = 3;
        L = pass_len(k);
        for (int i = 0; i < 64; i++) begin
            for (int c = 0; c < C; c++) begin av_h[i][c] = 0; ae_h[i][c] = 0; aa_h[i][c] = 0; end
            for (int r = 0; r < R; r++) begin wv_h[i][r] = 0; we_h[i][r] = 0; wa_h[i][r] = 0; end
        end
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) meets[r][c] = 0;
        bus.K_Len = KW'(k);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        for (int i = 1; i <= L; i++) begin
            for (int c = 0; c < C; c++) begin
                av_h[i][c] = bus.Act_Valids[c];
                ae_h[i][c] = bus.Act_Rd_En[c];
                aa_h[i][c] = int'(bus.Act_Rd_Addr[c*KW +: KW]);
            end
            for (int r = 0; r < R; r++) begin
                wv_h[i][r] = bus.Weight_Valids[r];
                we_h[i][r] = bus.Weight_Rd_En[r];
                wa_h[i][r] = int'(bus.Weight_Rd_Addr[r*KW +: KW]);
            end
            tick();
        end
        for (int i = 2; i <= L; i++)
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++) begin
                    na = (i - r >= 2) ? int'(av_h[i-r][c]) : 0;
                    nw = (i - c >= 2) ? int'(wv_h[i-c][r]) : 0;
                    da = (i - r >= 2 && ae_h[i-r-1][c]) ? aa_h[i-r-1][c] : -1;
                    dw = (i - c >= 2 && we_h[i-c-1][r]) ? wa_h[i-c-1][r] : -1;
                    if (na != 0 || nw != 0) begin
                        checks++;
                        if (na == 0 || nw == 0 || da != dw || da < 0 || (i - 2) != da + r + c + 1) begin
                            errors++;
                            $display("FAIL meet node=(%0d,%0d) T=%0d act v=%0d step=%0d wgt v=%0d step=%0d",
                                     r, c, i - 2, na, da, nw, dw);
                        end else meets[r][c]++;
                    end
                end
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                checks++;
                if (meets[r][c] != k) begin
                    errors++;
                    $display("FAIL meet_count node=(%0d,%0d) got %0d required %0d", r, c, meets[r][c], k);
                end
            end
    endtask

    task automatic test_k0();
        logic [2+R+C-1:0] got, exp;
        bus.K_Len = '0;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            exp = {(i <= 2), (i == 2), (i == 1) ? {R{1'b1}} : {R{1'b0}}, (i == 1) ? {C{1'b1}} : {C{1'b0}}};
            got = {bus.Busy, bus.Done, bus.Clear_Row, bus.Clear_Col};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL k0_ctl cyc=%0d got %b required %b", i, got, exp);
            end
            checks++;
            if ({bus.Act_Rd_En, bus.Weight_Rd_En, bus.Act_Valids, bus.Weight_Valids} !== '0) begin
                errors++;
                $display("FAIL k0_no_stream cyc=%0d got %b required 0", i,
                         {bus.Act_Rd_En, bus.Weight_Rd_En, bus.Act_Valids, bus.Weight_Valids});
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int L;
        int clr_q[$], done_q[$];
        L = pass_len(2);
        bus.K_Len = KW'(2);
        bus.Start = 1'b1;
        tick();
        for (int i = 1; i <= 2 * L; i++) begin
            if (bus.Clear_Row == {R{1'b1}}) clr_q.push_back(i);
            if (bus.Done) done_q.push_back(i);
            bus.Start = (i <= L);
            bus.K_Len = (i == L) ? KW'(2) : KW'($urandom_range(0, 255));
            tick();
        end
        checks++;
        if (clr_q.size() != 2 || done_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_counts clears=%0d dones=%0d required 2 and 2", clr_q.size(), done_q.size());
        end else begin
            checks++;
            if (clr_q[0] != 1 || done_q[0] != L - 1) begin
                errors++;
                $display("FAIL b2b_first clear=%0d done=%0d required %0d %0d", clr_q[0], done_q[0], 1, L - 1);
            end
            checks++;
            if (clr_q[1] != done_q[0] + 2 || done_q[1] != 2 * L - 1) begin
                errors++;
                $display("FAIL b2b_second clear=%0d done=%0d required %0d %0d",
                         clr_q[1], done_q[1], done_q[0] + 2, 2 * L - 1);
            end
        end
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle busy got %b required 0", bus.Busy);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bus.K_Len = KW'($urandom_range(3, 20));
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (all_out() !== '0) begin
            errors++;
            $display("FAIL reset_mid got %h required 0", all_out());
        end
        bus.K_Len = KW'(1);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        checks++;
        if ({bus.Busy, bus.Clear_Row, bus.Clear_Col} !== {1'b1, {R{1'b1}}, {C{1'b1}}}) begin
            errors++;
            $display("FAIL reset_mid_restart got %b required all ones", {bus.Busy, bus.Clear_Row, bus.Clear_Col});
        end
        n = 0;
        while (bus.Busy && n < 200) begin tick(); n++; end
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_timeout busy got %b required 0", bus.Busy);
        end
    endtask

`ifdef SYSTOLIC_SEQ_ABORT_EN
    task automatic test_abort();
        int n, dones;
        bus.K_Len = KW'($urandom_range(3, 20));
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (all_out() !== '0) begin
            errors++;
            $display("FAIL abort_idle got %h required 0", all_out());
        end
        bus.K_Len = KW'(2);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        checks++;
        if ({bus.Busy, bus.Clear_Row} !== {1'b1, {R{1'b1}}}) begin
            errors++;
            $display("FAIL abort_restart got %b required all ones", {bus.Busy, bus.Clear_Row});
        end
        n = 0;
        dones = 0;
        while (bus.Busy && n < 200) begin
            if (bus.Done) dones++;
            tick();
            n++;
        end
        checks++;
        if (dones != 1 || n != pass_len(2) - 1) begin
            errors++;
            $display("FAIL abort_followup dones=%0d len=%0d required 1 %0d", dones, n, pass_len(2) - 1);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        bus.Start = 1'b0;
        bus.K_Len = '0;
`ifdef SYSTOLIC_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        test_reset();
        test_pass(3, 1'b0);
        test_meet();
        test_k0();
        test_pass(255, 1'b0);
        test_pass(1, 1'b1);
        repeat (4) test_pass(int'($urandom_range(1, 12)), 1'b1);
        test_back_to_back();
        test_reset_mid();
`ifdef SYSTOLIC_SEQ_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
